// File: rtl/fetch_pkg.sv
// Shared types and constants for the LEGv8 instruction-fetch front end.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

  localparam logic [1:0] BR_SEQ   = 2'b00;
  localparam logic [1:0] BR_PCREL = 2'b01;
  localparam logic [1:0] BR_REG   = 2'b10;

  localparam int BRADDR26_MSB   = 25;
  localparam int BRADDR26_LSB   = 0;
  localparam int CONDADDR19_MSB = 23;
  localparam int CONDADDR19_LSB = 5;

  localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory request/response plus decoder-side handshake.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 64
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic              imem_rvalid;
  logic [31:0]       imem_rdata;
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instruction;
  logic [ADDR_W-1:0] instr_pc;
  logic [ADDR_W-1:0] link_addr;
  logic [1:0]        br_taken;
  logic              uncond_br;
  logic [ADDR_W-1:0] br_reg;

  modport master (
    output imem_req, imem_addr, instr_valid, instruction, instr_pc, link_addr,
    input  imem_ready, imem_rvalid, imem_rdata, instr_ready, br_taken, uncond_br, br_reg
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instruction, instr_pc, link_addr,
    output imem_ready, imem_rvalid, imem_rdata, instr_ready, br_taken, uncond_br, br_reg
  );
endinterface

// File: rtl/branch_target_calc.sv
// Combinational next-PC selection from the decoder's branch outputs.
module branch_target_calc
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic [ADDR_W-1:0] instr_pc,
  input  logic [31:0]       instruction,
  input  logic [1:0]        br_taken,
  input  logic              uncond_br,
  input  logic [ADDR_W-1:0] br_reg,
  output logic [ADDR_W-1:0] next_pc,
  output logic              misalign
);
  localparam int W26 = BRADDR26_MSB - BRADDR26_LSB + 1;
  localparam int W19 = CONDADDR19_MSB - CONDADDR19_LSB + 1;

  logic signed [W26-1:0]    imm26;
  logic signed [W19-1:0]    imm19;
  logic signed [ADDR_W-1:0] off26;
  logic signed [ADDR_W-1:0] off19;
  logic                     unused_fields;

  assign imm26 = instruction[BRADDR26_MSB:BRADDR26_LSB];
  assign imm19 = instruction[CONDADDR19_MSB:CONDADDR19_LSB];
  // Word offsets become byte offsets: sign-extend, then append two zero bits.
  assign off26 = {{(ADDR_W-W26-2){imm26[W26-1]}}, imm26, 2'b00};
  assign off19 = {{(ADDR_W-W19-2){imm19[W19-1]}}, imm19, 2'b00};
  assign unused_fields = ^{instruction[31:BRADDR26_MSB+1], instruction[CONDADDR19_LSB-1:0]};

  always_comb begin
    next_pc  = instr_pc + ADDR_W'(INSTR_BYTES);
    misalign = 1'b0;
    case (br_taken)
      BR_PCREL: next_pc = instr_pc + (uncond_br ? off26 : off19);
      BR_REG: begin
        next_pc  = {br_reg[ADDR_W-1:2], 2'b00};
        misalign = |br_reg[1:0];
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// LEGv8 fetch front end: one outstanding imem read, one held instruction, branch redirect on consume.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  instr_fetch_unit_if.master  bus,
  output logic                err_spurious,
  output logic                err_misalign
);
  fetch_state_e      state;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] next_pc;
  logic              misalign;
  logic              consume;

  branch_target_calc #(.ADDR_W(ADDR_W)) u_btc (
    .instr_pc    (bus.instr_pc),
    .instruction (bus.instruction),
    .br_taken    (bus.br_taken),
    .uncond_br   (bus.uncond_br),
    .br_reg      (bus.br_reg),
    .next_pc     (next_pc),
    .misalign    (misalign)
  );

  assign consume = bus.instr_valid & bus.instr_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      req_addr         <= RESET_PC;
      bus.imem_req     <= 1'b0;
      bus.imem_addr    <= RESET_PC;
      bus.instr_valid  <= 1'b0;
      bus.instruction  <= '0;
      bus.instr_pc     <= '0;
      bus.link_addr    <= ADDR_W'(INSTR_BYTES);
      err_spurious     <= 1'b0;
      err_misalign     <= 1'b0;
    end else begin
      // Only WAIT expects read data; anything else is a protocol violation.
      if (bus.imem_rvalid && state != WAIT)
        err_spurious <= 1'b1;

      case (state)
        IDLE: begin
          state        <= REQ;
          bus.imem_req <= 1'b1;
        end
        REQ: begin
          if (bus.imem_ready) begin
            state        <= WAIT;
            bus.imem_req <= 1'b0;
          end
        end
        WAIT: begin
          if (bus.imem_rvalid) begin
            state           <= HOLD;
            bus.instruction <= bus.imem_rdata;
            bus.instr_pc    <= req_addr;
            bus.link_addr   <= req_addr + ADDR_W'(INSTR_BYTES);
            bus.instr_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (consume) begin
            state           <= REQ;
            req_addr        <= next_pc;
            bus.imem_addr   <= next_pc;
            bus.imem_req    <= 1'b1;
            bus.instr_valid <= 1'b0;
            if (misalign)
              err_misalign <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, hand-written corner sequences, randomized run.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  localparam int          AW  = 64;
  localparam logic [63:0] RPC = 64'h0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic err_spurious, err_misalign;

  instr_fetch_unit_if #(.ADDR_W(AW)) bus ();

  instr_fetch_unit #(.ADDR_W(AW), .RESET_PC(RPC)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus.master),
    .err_spurious (err_spurious),
    .err_misalign (err_misalign)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] word;
    logic [1:0]  br;
    logic        unc;
    logic [63:0] breg;
    logic [63:0] exp_pc;
    logic [63:0] exp_next;
    logic        exp_mis;
  } vec_t;

  vec_t tbl[14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) step();
    reset = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    int n = 0;
    while (!bus.imem_req && n < 50) begin
      step();
      n++;
    end
    ok = bus.imem_req;
  endtask

  // Accept one request at exp_addr after rdy_dly stalled cycles, return word after lat extra cycles.
  task automatic serve(input logic [31:0] word, input int rdy_dly, input int lat,
                       input logic [63:0] exp_addr, input string tag);
    bit ok;
    wait_req(ok);
    chk({tag, "_req_seen"}, 64'(ok), 64'd1);
    chk({tag, "_imem_addr"}, bus.imem_addr, exp_addr);
    for (int i = 0; i < rdy_dly; i++) begin
      bus.imem_ready = 1'b0;
      step();
      chk({tag, "_req_held"}, 64'(bus.imem_req), 64'd1);
      chk({tag, "_addr_held"}, bus.imem_addr, exp_addr);
    end
    bus.imem_ready = 1'b1;
    step();
    bus.imem_ready = 1'b0;
    chk({tag, "_req_drop"}, 64'(bus.imem_req), 64'd0);
    for (int i = 0; i < lat; i++) begin
      step();
      chk({tag, "_no_valid_yet"}, 64'(bus.instr_valid), 64'd0);
    end
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = word;
    step();
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = $urandom;
    chk({tag, "_valid"}, 64'(bus.instr_valid), 64'd1);
  endtask

  // Hold off dly cycles, then consume with the given branch outputs.
  task automatic consume(input logic [1:0] br, input logic unc, input logic [63:0] breg,
                         input int dly, input logic [31:0] exp_word, input logic [63:0] exp_pc,
                         input string tag);
    for (int i = 0; i < dly; i++) begin
      bus.instr_ready = 1'b0;
      bus.br_taken    = 2'($urandom);
      bus.br_reg      = {$urandom, $urandom};
      step();
      chk({tag, "_hold_valid"}, 64'(bus.instr_valid), 64'd1);
      chk({tag, "_hold_noreq"}, 64'(bus.imem_req), 64'd0);
      chk({tag, "_hold_word"}, 64'(bus.instruction), 64'(exp_word));
      chk({tag, "_hold_pc"}, bus.instr_pc, exp_pc);
    end
    bus.br_taken    = br;
    bus.uncond_br   = unc;
    bus.br_reg      = breg;
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
    bus.br_taken    = 2'($urandom);
    bus.uncond_br   = 1'($urandom);
    bus.br_reg      = {$urandom, $urandom};
    chk({tag, "_valid_clr"}, 64'(bus.instr_valid), 64'd0);
  endtask

  function automatic logic [63:0] ref_next(input logic [63:0] pc, input logic [31:0] word,
                                           input logic [1:0] br, input logic unc,
                                           input logic [63:0] breg);
    logic signed [25:0] i26;
    logic signed [18:0] i19;
    longint off;
    case (br)
      2'b01: begin
        if (unc) begin
          i26 = word[25:0];
          off = i26;
        end else begin
          i19 = word[23:5];
          off = i19;
        end
        return pc + 64'(off * 4);
      end
      2'b10:   return breg & ~64'h3;
      default: return pc + 64'd4;
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] pc;
    logic        mis;
    logic [31:0] w;
    logic [1:0]  br;
    logic        unc;
    logic [63:0] breg, nxt;
    int          prev;
    bit          ok;

    bus.imem_ready  = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.instr_ready = 1'b0;
    bus.br_taken    = '0;
    bus.uncond_br   = 1'b0;
    bus.br_reg      = '0;

    //                word                         br     unc   breg                    pc                      next                    mis
    tbl[0]  = '{32'hA000_0001,                  2'b00, 1'b0, 64'h0,                  64'h0,                  64'h4,                  1'b0};
    tbl[1]  = '{32'hB000_0002,                  2'b00, 1'b0, 64'h0,                  64'h4,                  64'h8,                  1'b0};
    tbl[2]  = '{32'hC000_0003,                  2'b10, 1'b0, 64'h10,                 64'h8,                  64'h10,                 1'b0};
    tbl[3]  = '{{6'b000101, 26'h3FF_FFFE},      2'b01, 1'b1, 64'h0,                  64'h10,                 64'h08,                 1'b0};
    tbl[4]  = '{32'hD000_0004,                  2'b10, 1'b0, 64'h20,                 64'h08,                 64'h20,                 1'b0};
    tbl[5]  = '{{8'hB4, 19'd3, 5'd0},           2'b01, 1'b0, 64'h0,                  64'h20,                 64'h2C,                 1'b0};
    tbl[6]  = '{32'hE000_0005,                  2'b10, 1'b0, 64'h20,                 64'h2C,                 64'h20,                 1'b0};
    tbl[7]  = '{{8'hB4, 19'd3, 5'd0},           2'b00, 1'b0, 64'h0,                  64'h20,                 64'h24,                 1'b0};
    tbl[8]  = '{32'hF000_0006,                  2'b11, 1'b1, 64'h0,                  64'h24,                 64'h28,                 1'b0};
    tbl[9]  = '{32'h1234_5678,                  2'b10, 1'b0, 64'h1000,               64'h28,                 64'h1000,               1'b0};
    tbl[10] = '{32'h8765_4321,                  2'b10, 1'b0, 64'h1006,               64'h1000,               64'h1004,               1'b1};
    tbl[11] = '{32'h0F0F_0F0F,                  2'b00, 1'b0, 64'h0,                  64'h1004,               64'h1008,               1'b1};
    tbl[12] = '{32'h5555_AAAA,                  2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h1008,               64'hFFFF_FFFF_FFFF_FFFC, 1'b1};
    tbl[13] = '{32'hAAAA_5555,                  2'b00, 1'b0, 64'h0,                  64'hFFFF_FFFF_FFFF_FFFC, 64'h0,                  1'b1};

    // Reset state
    do_reset(2);
    chk("rst_imem_req", 64'(bus.imem_req), 64'd0);
    chk("rst_imem_addr", bus.imem_addr, RPC);
    chk("rst_instr_valid", 64'(bus.instr_valid), 64'd0);
    chk("rst_instruction", 64'(bus.instruction), 64'd0);
    chk("rst_instr_pc", bus.instr_pc, 64'd0);
    chk("rst_link_addr", bus.link_addr, 64'd4);
    chk("rst_err_spurious", 64'(err_spurious), 64'd0);
    chk("rst_err_misalign", 64'(err_misalign), 64'd0);

    // Directed vector table, zero-latency memory, immediate consume
    prev = 0;
    foreach (tbl[i]) begin
      serve(tbl[i].word, 0, 0, tbl[i].exp_pc, $sformatf("v%0d", i));
      if (i > 0) chk($sformatf("v%0d_cadence", i), 64'(cyc - prev), 64'd3);
      prev = cyc;
      chk($sformatf("v%0d_instr_pc", i), bus.instr_pc, tbl[i].exp_pc);
      chk($sformatf("v%0d_link", i), bus.link_addr, tbl[i].exp_pc + 64'd4);
      chk($sformatf("v%0d_word", i), 64'(bus.instruction), 64'(tbl[i].word));
      consume(tbl[i].br, tbl[i].unc, tbl[i].breg, 0, tbl[i].word, tbl[i].exp_pc,
              $sformatf("v%0d", i));
      chk($sformatf("v%0d_next_req", i), 64'(bus.imem_req), 64'd1);
      chk($sformatf("v%0d_next_addr", i), bus.imem_addr, tbl[i].exp_next);
      chk($sformatf("v%0d_misalign", i), 64'(err_misalign), 64'(tbl[i].exp_mis));
    end

    // Backpressure on both sides
    do_reset(2);
    serve(32'hCAFE_0001, 3, 0, RPC, "bp");
    consume(2'b00, 1'b0, 64'h0, 4, 32'hCAFE_0001, RPC, "bp");
    chk("bp_next_addr", bus.imem_addr, RPC + 64'd4);
    chk("bp_err_misalign_clr", 64'(err_misalign), 64'd0);

    // Reset while WAIT, then a late response after reset release
    wait_req(ok);
    chk("rs_req_seen", 64'(ok), 64'd1);
    bus.imem_ready = 1'b1;
    step();
    bus.imem_ready = 1'b0;
    do_reset(2);
    chk("rs_req_after_reset", 64'(bus.imem_req), 64'd0);
    chk("rs_spur_after_reset", 64'(err_spurious), 64'd0);
    step();
    step();
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hDEAD_BEEF;
    step();
    bus.imem_rvalid = 1'b0;
    chk("rs_err_spurious", 64'(err_spurious), 64'd1);
    chk("rs_valid_ignored", 64'(bus.instr_valid), 64'd0);
    chk("rs_req_still", 64'(bus.imem_req), 64'd1);
    chk("rs_restart_addr", bus.imem_addr, RPC);
    serve(32'h1111_2222, 0, 1, RPC, "rs");
    chk("rs_clean_word", 64'(bus.instruction), 64'h1111_2222);
    chk("rs_spurious_sticky", 64'(err_spurious), 64'd1);
    consume(2'b00, 1'b0, 64'h0, 0, 32'h1111_2222, RPC, "rs");

    // Randomized run against the reference model
    do_reset(1);
    pc  = RPC;
    mis = 1'b0;
    for (int n = 0; n < 40; n++) begin
      w    = $urandom;
      br   = 2'($urandom_range(0, 3));
      unc  = 1'($urandom_range(0, 1));
      breg = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) breg[1:0] = 2'b00;
      serve(w, $urandom_range(0, 2), $urandom_range(0, 2), pc, $sformatf("r%0d", n));
      chk($sformatf("r%0d_instr_pc", n), bus.instr_pc, pc);
      chk($sformatf("r%0d_link", n), bus.link_addr, pc + 64'd4);
      chk($sformatf("r%0d_word", n), 64'(bus.instruction), 64'(w));
      consume(br, unc, breg, $urandom_range(0, 2), w, pc, $sformatf("r%0d", n));
      nxt = ref_next(pc, w, br, unc, breg);
      if (br == 2'b10 && breg[1:0] != 2'b00) mis = 1'b1;
      chk($sformatf("r%0d_next_addr", n), bus.imem_addr, nxt);
      chk($sformatf("r%0d_misalign", n), 64'(err_misalign), 64'(mis));
      chk($sformatf("r%0d_spurious", n), 64'(err_spurious), 64'd0);
      pc = nxt;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
